// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter sharing one LSB-first serial link among N_REQ parallel requesters.
// Define SERIAL_LINK_GAP_EN to force an idle cycle between words (accepts only from IDLE).
//
// state | meaning
// IDLE  | link quiet, any valid requester may be accepted
// SHIFT | word being shifted out, one bit per cycle, bit_cnt = bit index
module serial_link_arbiter #(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*WIDTH-1:0]     req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       serial_valid,
   output logic                       serial_data,
   output logic                       serial_last,
   output logic [$clog2(N_REQ)-1:0]   serial_id,
   output logic                       busy
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic [WIDTH-1:0]  shift_reg, shift_nxt;
   logic [ID_W-1:0]   serial_id_nxt;
   logic [ID_W-1:0]   last_grant, last_grant_nxt;

   logic [WIDTH-1:0]  words [N_REQ];
   logic              on_last;
   logic              accept_slot;
   logic              accept;
   logic              grant_found;
   logic [ID_W-1:0]   grant_idx;
   int                cand;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         words[i] = req_data[i*WIDTH +: WIDTH];
      end
   end

   assign on_last = (state == SHIFT) && (bit_cnt == CNT_LAST);

`ifdef SERIAL_LINK_GAP_EN
   assign accept_slot = !rst && (state == IDLE);
`else
   // Accepting on the last bit lets the next word follow with no dead cycle.
   assign accept_slot = !rst && ((state == IDLE) || on_last);
`endif

   // Search upward from the requester after the previous grant, wrapping around.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(last_grant) + k) % N_REQ;
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   assign accept = accept_slot && grant_found;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      state_nxt      = state;
      bit_cnt_nxt    = bit_cnt;
      shift_nxt      = shift_reg;
      serial_id_nxt  = serial_id;
      last_grant_nxt = last_grant;
      if (accept) begin
         state_nxt      = SHIFT;
         bit_cnt_nxt    = '0;
         shift_nxt      = words[grant_idx];
         serial_id_nxt  = grant_idx;
         last_grant_nxt = grant_idx;
      end else if (state == SHIFT) begin
         if (on_last) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            shift_nxt   = '0;
         end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            shift_nxt   = {1'b0, shift_reg[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         serial_id  <= '0;
         last_grant <= ID_LAST;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shift_reg  <= shift_nxt;
         serial_id  <= serial_id_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   assign busy         = (state == SHIFT);
   assign serial_valid = (state == SHIFT);
   assign serial_data  = (state == SHIFT) && shift_reg[0];
   assign serial_last  = on_last;

endmodule
